// File: rtl/selftest_seq.sv
// Power-on lamp test sequencer for the LED matrix and 7-segment buses: red, green, yellow, blinking digits.
// Optional digit-walk phase after the blink steps is compiled in when SELFTEST_DIGIT_WALK_EN is defined.
module selftest_seq #(
  parameter int CLK_DIV     = 25_000_000,
  parameter int PIXELS      = 64,
  parameter int DIGITS      = 8,
  parameter int BLINK_STEPS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  skip,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            step,
  output logic [2*PIXELS-1:0]   matrixData,
  output logic [4*DIGITS-1:0]   numbersData
);

`ifdef SELFTEST_DIGIT_WALK_EN
  localparam int WALK_STEPS = DIGITS - 1;
`else
  localparam int WALK_STEPS = 0;
`endif
  localparam int N_STEPS = 3 + BLINK_STEPS + WALK_STEPS;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam int WD      = DIGITS - 1;
  localparam int LOW_W   = 4 * WD;
  localparam logic [LOW_W-1:0] BLANK = {WD{4'hf}};

  if (N_STEPS > 15) begin : g_bad_steps
    $error("selftest_seq: total step count must not exceed 15");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("selftest_seq: CLK_DIV must be at least 2");
  end
  if (DIGITS < 2 || BLINK_STEPS < 1) begin : g_bad_digits
    $error("selftest_seq: need DIGITS >= 2 and BLINK_STEPS >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RED, S_GREEN, S_YELLOW, S_DIGIT, S_DONE
`ifdef SELFTEST_DIGIT_WALK_EN
    , S_WALK
`endif
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic [3:0]       sub;
  logic             tc;

  function automatic logic [1:0] colour(state_t s);
    case (s)
      S_RED:    return 2'b10;
      S_GREEN:  return 2'b01;
      S_YELLOW: return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  function automatic logic [LOW_W-1:0] lower_on(state_t s);
    return (s == S_DIGIT) ? {WD{4'h8}} : BLANK;
  endfunction

  // State reached at the next step boundary; sub counts steps spent in multi-step states.
  function automatic state_t next_of(state_t s, logic [3:0] k);
    case (s)
      S_RED:    return S_GREEN;
      S_GREEN:  return S_YELLOW;
      S_YELLOW: return S_DIGIT;
`ifdef SELFTEST_DIGIT_WALK_EN
      S_DIGIT:  return (k == 4'(BLINK_STEPS - 1)) ? S_WALK : S_DIGIT;
      S_WALK:   return (k == 4'(DIGITS - 2)) ? S_DONE : S_WALK;
`else
      S_DIGIT:  return (k == 4'(BLINK_STEPS - 1)) ? S_DONE : S_DIGIT;
`endif
      default:  return s;
    endcase
  endfunction

  assign nxt = next_of(state, sub);
  assign tc  = (cnt == CNT_W'(CLK_DIV - 1));

`ifdef SELFTEST_DIGIT_WALK_EN
  logic [WD-1:0] walk_oh;
  logic [WD-1:0] walk_nx;

  function automatic logic [LOW_W-1:0] expand(logic [WD-1:0] oh);
    logic [LOW_W-1:0] p;
    p = BLANK;
    for (int i = 0; i < WD; i++) begin
      if (oh[i]) p[4*i +: 4] = 4'h8;
    end
    return p;
  endfunction

  assign walk_nx = (state == S_WALK) ? (walk_oh << 1) : WD'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      phase       <= 1'b0;
      sub         <= '0;
      step        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      matrixData  <= '0;
      numbersData <= {4'h0, BLANK};
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RED;
            cnt         <= '0;
            phase       <= 1'b0;
            sub         <= '0;
            step        <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            matrixData  <= {PIXELS{colour(S_RED)}};
            numbersData <= {4'h0, BLANK};
          end
        end
        default: begin
          if (skip) begin
            // Abort wins over a coincident step boundary: step is frozen.
            state       <= S_DONE;
            cnt         <= '0;
            phase       <= 1'b0;
            sub         <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            matrixData  <= '0;
            numbersData <= {step, BLANK};
          end else if (!tc) begin
            cnt <= cnt + CNT_W'(1);
          end else if (!phase) begin
            cnt                      <= '0;
            phase                    <= 1'b1;
            matrixData               <= '0;
            numbersData[LOW_W-1:0]   <= BLANK;
          end else begin
            cnt         <= '0;
            phase       <= 1'b0;
            state       <= nxt;
            sub         <= (nxt == state) ? sub + 4'd1 : 4'd0;
            step        <= step + 4'd1;
            matrixData  <= {PIXELS{colour(nxt)}};
            numbersData <= {step + 4'd1, lower_on(nxt)};
`ifdef SELFTEST_DIGIT_WALK_EN
            walk_oh <= walk_nx;
            if (nxt == S_WALK) numbersData[LOW_W-1:0] <= expand(walk_nx);
`endif
            if (nxt == S_DONE) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_selftest_seq.sv
// Bench for selftest_seq: directed and randomized steps checked each cycle against a step/phase arithmetic model.
module tb_selftest_seq;
  localparam int CD = 4;
  localparam int PX = 64;
  localparam int DG = 8;
  localparam int BS = 3;
  localparam int CD2 = 2;
`ifdef SELFTEST_DIGIT_WALK_EN
  localparam int WS  = DG - 1;
  localparam int WS2 = 3;
`else
  localparam int WS  = 0;
  localparam int WS2 = 0;
`endif
  localparam int N  = 3 + BS + WS;
  localparam int N2 = 3 + 3 + WS2;

  logic          clk = 1'b0;
  logic          start = 1'b0, skip = 1'b0, rst = 1'b0, start2 = 1'b0;
  logic          busy, done, busy2, done2;
  logic [3:0]    step, step2;
  logic [127:0]  matrix;
  logic [31:0]   numbers;
  logic [31:0]   matrix2;
  logic [15:0]   numbers2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model: mode 0 idle, 1 running, 2 done; k = edges since the start edge
  int m_mode = 0;
  int m_k = 0;
  int m_step = 0;

  selftest_seq #(.CLK_DIV(CD), .PIXELS(PX), .DIGITS(DG), .BLINK_STEPS(BS)) dut (
    .clk(clk), .rst(rst), .start(start), .skip(skip), .busy(busy), .done(done),
    .step(step), .matrixData(matrix), .numbersData(numbers));

  selftest_seq #(.CLK_DIV(CD2), .PIXELS(16), .DIGITS(4), .BLINK_STEPS(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .skip(1'b0), .busy(busy2), .done(done2),
    .step(step2), .matrixData(matrix2), .numbersData(numbers2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit s, input bit k, input bit r);
    if (r) begin
      m_mode = 0; m_step = 0;
    end else if (m_mode == 1) begin
      if (k) begin
        m_mode = 2;
      end else begin
        m_k++;
        if (m_k / (2*CD) >= N) begin m_mode = 2; m_step = N; end
        else m_step = m_k / (2*CD);
      end
    end else if (s) begin
      m_mode = 1; m_k = 0; m_step = 0;
    end
  endtask

  function automatic logic [1:0] exp_col();
    int s;
    s = m_k / (2*CD);
    if (m_mode != 1 || ((m_k / CD) % 2) != 0) return 2'b00;
    if (s == 0) return 2'b10;
    if (s == 1) return 2'b01;
    if (s == 2) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_num();
    logic [31:0] v;
    int s;
    bit on;
    s  = m_k / (2*CD);
    on = (m_mode == 1) && (((m_k / CD) % 2) == 0);
    v  = '0;
    for (int i = 0; i < DG-1; i++) begin
      v[4*i +: 4] = 4'hf;
      if (on && s >= 3 && s < 3+BS) v[4*i +: 4] = 4'h8;
      if (on && s >= 3+BS && (s-3-BS) == i) v[4*i +: 4] = 4'h8;
    end
    v[31:28] = 4'(m_step);
    return v;
  endfunction

  task automatic check_all();
    chk("busy", 128'(busy), 128'(m_mode == 1));
    chk("done", 128'(done), 128'(m_mode == 2));
    chk("step", 128'(step), 128'(m_step));
    chk("matrix", matrix, {PX{exp_col()}});
    chk("numbers", 128'(numbers), 128'(exp_num()));
  endtask

  task automatic tick(input bit s, input bit k, input bit r);
    start = s; skip = k; rst = r;
    @(posedge clk);
    model_edge(s, k, r);
    @(negedge clk);
    start = 1'b0; skip = 1'b0; rst = 1'b0;
    cyc++;
    check_all();
  endtask

  initial begin
    int n;
    @(negedge clk);
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 1, 0);

    // full run with no disturbance
    tick(1, 0, 0);
    chk("red_first", matrix, {PX{2'b10}});
    n = 1;
    while (!done && n < 400) begin tick(0, 0, 0); n++; end
    chk("latency", 128'(n), 128'(2*CD*N + 1));
    chk("done_num", 128'(numbers), 128'({4'(N), 28'hfffffff}));

    // start pulses while busy are ignored
    tick(1, 0, 0);
    n = 1;
    while (!done && n < 400) begin tick(($urandom % 5) == 0, 0, 0); n++; end
    chk("latency_hs", 128'(n), 128'(2*CD*N + 1));

    // reset mid-run then restart
    tick(1, 0, 0);
    repeat (19) tick(0, 0, 0);
    tick(0, 0, 1);
    chk("rst_num", 128'(numbers), 128'(32'h0fffffff));
    tick(1, 0, 0);
    chk("restart_red", matrix, {PX{2'b10}});

    // skip during green
    repeat (9) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("skip_step", 128'(step), 128'(1));
    chk("skip_busy", 128'(busy), 128'(0));

    // start in DONE, then skip exactly on a step boundary edge
    tick(1, 0, 0);
    chk("restart_step", 128'(step), 128'(0));
    repeat (2*2*CD - 1) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("skip_bnd_step", 128'(step), 128'(1));

    // parameter sweep instance
    start2 = 1'b1;
    tick(0, 0, 0);
    start2 = 1'b0;
    chk("sw_red", 128'(matrix2), 128'(32'haaaaaaaa));
    n = 1;
    while (!done2 && n < 400) begin tick(0, 0, 0); n++; end
    chk("sw_latency", 128'(n), 128'(2*CD2*N2 + 1));
    chk("sw_step", 128'(step2), 128'(N2));
    chk("sw_num", 128'(numbers2), 128'({4'(N2), 12'hfff}));
    chk("sw_busy", 128'(busy2), 128'(0));

    // randomized runs with sporadic start, skip and reset
    for (int r = 0; r < 8; r++) begin
      tick(1, 0, 0);
      n = 0;
      while (m_mode == 1 && n < 2*CD*N + 10) begin
        tick(($urandom % 6) == 0, ($urandom % 40) == 0, ($urandom % 90) == 0);
        n++;
      end
      repeat (3) tick(0, ($urandom % 2) == 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
